dma_multiword_engine: RTL

//  Single-channel, APB-programmed DMA engine that copies N 32-bit words between two

---
 rtl/dma_multiword_engine.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dma_multiword_engine.sv
// Single-channel APB-programmed DMA copying N 32-bit words between mem0/mem1 (2 cycles/word).
// Optional DMA_INTR_MASK_EN adds a MASK register at 0x18 gating INTR.
module dma_multiword_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int MEM_SEL_BIT    = 20
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  output logic                      INTR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  output logic                      PREADY,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      mem0_en,
  output logic [3:0]                mem0_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem0_addr,
  output logic [DATA_WIDTH-1:0]     mem0_wdata,
  input  logic [DATA_WIDTH-1:0]     mem0_rdata,
  output logic                      mem1_en,
  output logic [3:0]                mem1_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem1_addr,
  output logic [DATA_WIDTH-1:0]     mem1_wdata,
  input  logic [DATA_WIDTH-1:0]     mem1_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [APB_ADDR_WIDTH-1:0] OFF_SRC  = APB_ADDR_WIDTH'('h00);
  localparam logic [APB_ADDR_WIDTH-1:0] OFF_DST  = APB_ADDR_WIDTH'('h04);
  localparam logic [APB_ADDR_WIDTH-1:0] OFF_SIZE = APB_ADDR_WIDTH'('h08);
  localparam logic [APB_ADDR_WIDTH-1:0] OFF_CTRL = APB_ADDR_WIDTH'('h0C);
  localparam logic [APB_ADDR_WIDTH-1:0] OFF_INT  = APB_ADDR_WIDTH'('h10);
  localparam logic [APB_ADDR_WIDTH-1:0] OFF_STAT = APB_ADDR_WIDTH'('h14);

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]     src_q, dst_q, size_q, rd_dat, src_rdata;
  logic [MEM_ADDR_WIDTH-1:0] src_ptr_q, dst_ptr_q;
  logic [CNT_WIDTH-1:0]      rem_q, words;
  logic                      src_sel_q, dst_sel_q, done_q;
  logic                      apb_wr, apb_rd, busy, start;
  logic                      is_src, is_dst, is_size, is_ctrl, is_int, is_stat;

  assign PREADY = PSEL & PENABLE;
  assign apb_wr = PREADY & PWRITE;
  assign apb_rd = PREADY & ~PWRITE;

  // The block expects the interconnect to present offsets with the base already stripped.
  assign is_src  = (PADDR == OFF_SRC);
  assign is_dst  = (PADDR == OFF_DST);
  assign is_size = (PADDR == OFF_SIZE);
  assign is_ctrl = (PADDR == OFF_CTRL);
  assign is_int  = (PADDR == OFF_INT);
  assign is_stat = (PADDR == OFF_STAT);

  assign busy  = (state_q != IDLE);
  assign words = size_q[CNT_WIDTH+1:2];
  assign start = apb_wr & is_ctrl & ~busy & PWDATA[0];

`ifdef DMA_INTR_MASK_EN
  localparam logic [APB_ADDR_WIDTH-1:0] OFF_MASK = APB_ADDR_WIDTH'('h18);
  logic is_mask, mask_q;
  assign is_mask = (PADDR == OFF_MASK);
  assign INTR    = done_q & mask_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                 mask_q <= 1'b0;
    else if (apb_wr & is_mask) mask_q <= PWDATA[0];
  end
`else
  assign INTR = done_q;
`endif

  // Programmed registers: frozen while a transfer is running
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      src_q  <= '0;
      dst_q  <= '0;
      size_q <= '0;
    end else if (apb_wr && !busy) begin
      if (is_src)  src_q  <= PWDATA;
      if (is_dst)  dst_q  <= PWDATA;
      if (is_size) size_q <= PWDATA;
    end
  end

  // Completion beats a simultaneous write-1-to-clear
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                               done_q <= 1'b0;
    else if (state_q == DONE)                done_q <= 1'b1;
    else if (apb_wr && is_int && PWDATA[0])  done_q <= 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      src_sel_q <= 1'b0;
      dst_sel_q <= 1'b0;
      rem_q     <= '0;
    end else if (start) begin
      src_ptr_q <= src_q[MEM_ADDR_WIDTH+1:2];
      dst_ptr_q <= dst_q[MEM_ADDR_WIDTH+1:2];
      src_sel_q <= src_q[MEM_SEL_BIT];
      dst_sel_q <= dst_q[MEM_SEL_BIT];
      rem_q     <= words;
    end else if (state_q == WR) begin
      // Word pointers wrap naturally at 2^MEM_ADDR_WIDTH
      src_ptr_q <= src_ptr_q + 1'b1;
      dst_ptr_q <= dst_ptr_q + 1'b1;
      rem_q     <= rem_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (words != '0) ? RD : DONE;
      RD:   state_d = WR;
      WR:   state_d = (rem_q == CNT_WIDTH'(1)) ? DONE : RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign src_rdata = src_sel_q ? mem0_rdata : mem1_rdata;

  // Memory ports decode straight from state so reset drops them without a clock
  always_comb begin
    mem0_en    = 1'b0;
    mem0_we    = 4'h0;
    mem0_addr  = '0;
    mem0_wdata = '0;
    mem1_en    = 1'b0;
    mem1_we    = 4'h0;
    mem1_addr  = '0;
    mem1_wdata = '0;
    case (state_q)
      RD: begin
        if (src_sel_q) begin
          mem0_en   = 1'b1;
          mem0_addr = src_ptr_q;
        end else begin
          mem1_en   = 1'b1;
          mem1_addr = src_ptr_q;
        end
      end
      WR: begin
        if (dst_sel_q) begin
          mem0_en    = 1'b1;
          mem0_we    = 4'hF;
          mem0_addr  = dst_ptr_q;
          mem0_wdata = src_rdata;
        end else begin
          mem1_en    = 1'b1;
          mem1_we    = 4'hF;
          mem1_addr  = dst_ptr_q;
          mem1_wdata = src_rdata;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_dat = '0;
    if (is_src)       rd_dat = src_q;
    else if (is_dst)  rd_dat = dst_q;
    else if (is_size) rd_dat = size_q;
    else if (is_ctrl) rd_dat[1] = busy;
    else if (is_int)  rd_dat[0] = done_q;
    else if (is_stat) rd_dat[CNT_WIDTH-1:0] = rem_q;
`ifdef DMA_INTR_MASK_EN
    else if (is_mask) rd_dat[0] = mask_q;
`endif
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)       PRDATA <= '0;
    else if (apb_rd) PRDATA <= rd_dat;
  end

endmodule
